video_pixel_packer: RTL and testbench
=====================================

Name: video_pixel_packer

Overview:
- Capture-side counterpart of the video shift-out path: collects the 2-bit pixel stream and repacks it into bytes, first pixel in bits [7:6].
- Sits between the pixel source (decoder/capture front end) and the frame-memory write port.
- A two-entry output FIFO with a valid/ready handshake absorbs memory-side stalls.
- Honours the same div2 half-rate pixel clocking as the shift-out path.

Parameters:
- FIFO_DEPTH, 2, output byte FIFO entries; legal values 2 or 4.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- div2  input  1  1 = pixels are sampled on alternate clk cycles (half rate); 0 = every cycle
- lineStart  input  1  start-of-line pulse; realigns pixel phase and byte boundary
- pixelValid  input  1  pixelData is meaningful this cycle
- pixelData  input  2  incoming pixel
- byteData  output  8  packed byte at the FIFO head
- byteValid  output  1  FIFO non-empty
- byteReady  input  1  consumer accepts byteData when byteValid && byteReady
- overflow  output  1  sticky; a completed byte was lost because the FIFO was full

Behaviour:
- Reset, synchronous, active-high: pixel count=0, assembly register=0, phase=0, FIFO empty. Outputs: byteValid=0, byteData=8'h00, overflow=0. Reset wins over every other input in the same cycle.
- Phase: a 1-bit register that toggles every clk while div2=1 and is held at 0 while div2=0.
- Sample strobe = pixelValid && (!div2 || phase==1). Pixels presented while the strobe is 0 are ignored.
- Packing: a 2-bit counter n selects the slot. Sample k of a byte (k=0..3) writes assembly[7-2k:6-2k]. The counter wraps 3->0.
- Byte completion: on the 4th sample, the byte {assembly[7:2], pixelData} is pushed to the FIFO in that same cycle. The byte becomes visible on byteValid/byteData the next cycle (latency 1 clk from the 4th sample).
- FIFO: first-in first-out. Pop occurs when byteValid && byteReady.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full; the pop frees the slot.
  - Push while full with no pop: the byte is dropped, overflow is set, and the FIFO contents are unchanged.
  - byteData holds the head entry. It holds its last value (not X) when empty.
- overflow clears only on reset.
- lineStart (takes priority over the strobe in the same cycle):
  - phase<=0, n<=0, assembly<=0; a sample coincident with lineStart is discarded.
  - Partial-byte handling depends on VIDEO_PACKER_PARTIAL_FLUSH_EN (see Optional Feature).
  - FIFO contents are unaffected.
- div2 change mid-byte: there is no realignment. The pixel count continues and phase follows the rule above.
- Pixel width is fixed at 2 and the byte at 8; no parameterised widths.

Optional Feature:
- Macro VIDEO_PACKER_PARTIAL_FLUSH_EN.
- Defined: lineStart with n!=0 pushes the partial byte to the FIFO, with unfilled low slots zero-padded (e.g. 2 pixels 2'b11,2'b01 -> 8'hD0). The push follows the normal full/overflow rules.
- Undefined: a partial byte at lineStart is silently discarded; nothing is pushed.

Test Plan:
1. div2=0, byteReady=1: pixels 3,2,1,0 on consecutive cycles -> byteData=8'hE4 with byteValid=1 for exactly one cycle, 1 clk after the 4th pixel.
2. div2=1, pixelValid held high, pixelData changes every clk with sequence 3,0,2,0,1,0,0,0 from the first cycle after reset -> only odd-cycle values are sampled (0,0,0,0) -> byte 8'h00. Repeat with the phase-1 values 1,2,3,0 -> 8'h6C.
3. byteReady=0, push 3 bytes (8'h11, 8'h22, 8'h33), FIFO_DEPTH=2 -> FIFO holds 11,22; overflow=1; then byteReady=1 -> pops 11 then 22, then byteValid=0.
4. FIFO full, 4th pixel coincident with a pop -> no overflow; order is preserved.
5. Two pixels 3,1, then lineStart -> flush build: 8'hD0 emitted; non-flush build: nothing emitted. Then 4 pixels 0,1,2,3 -> 8'h1B in both builds.
6. Assert reset mid-byte with the FIFO non-empty -> next cycle byteValid=0, overflow=0. The next 4 pixels form a fresh byte starting at [7:6].

Source files
------------

// File: rtl/video_pixel_packer_if.sv
// Pixel-in / byte-out bundle for video_pixel_packer.
// The slave modport is the packer side; the master modport is the pixel source plus the memory consumer.
interface video_pixel_packer_if;
    logic       div2;
    logic       lineStart;
    logic       pixelValid;
    logic [1:0] pixelData;
    logic [7:0] byteData;
    logic       byteValid;
    logic       byteReady;
    logic       overflow;

    modport slave (
        input  div2, lineStart, pixelValid, pixelData, byteReady,
        output byteData, byteValid, overflow
    );

    modport master (
        output div2, lineStart, pixelValid, pixelData, byteReady,
        input  byteData, byteValid, overflow
    );
endinterface

// File: rtl/video_pixel_packer.sv
// Packs 2-bit pixels into bytes (first pixel in [7:6]) and queues them in a small output FIFO.
// Define VIDEO_PACKER_PARTIAL_FLUSH_EN to push zero-padded partial bytes on lineStart.
module video_pixel_packer #(
    parameter int FIFO_DEPTH = 2
) (
    input logic                  clk,
    input logic                  reset,
    video_pixel_packer_if.slave  bus
);
    // Handshake: a byte transfers on any clk edge where byteValid && byteReady; byteValid never depends on byteReady.
    localparam int AW = (FIFO_DEPTH == 4) ? 2 : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic          r_phase;
    logic [1:0]    r_n;
    logic [7:0]    r_asm;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_last;
    logic          r_overflow;

    logic          w_sample;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_wr_en;
    logic [7:0]    w_asm_next;
    logic [7:0]    w_push_data;

    always_comb begin
        w_sample   = bus.pixelValid && (!bus.div2 || r_phase) && !bus.lineStart;
        w_asm_next = r_asm;
        case (r_n)
            2'd0:    w_asm_next[7:6] = bus.pixelData;
            2'd1:    w_asm_next[5:4] = bus.pixelData;
            2'd2:    w_asm_next[3:2] = bus.pixelData;
            default: w_asm_next[1:0] = bus.pixelData;
        endcase
`ifdef VIDEO_PACKER_PARTIAL_FLUSH_EN
        w_push = (w_sample && (r_n == 2'd3)) || (bus.lineStart && (r_n != 2'd0));
`else
        w_push = w_sample && (r_n == 2'd3);
`endif
        // Unfilled low slots of r_asm are already zero, so a flush needs no extra masking.
        w_push_data = bus.lineStart ? r_asm : w_asm_next;
        w_full      = (r_count == FULL_CNT);
        w_pop       = (r_count != '0) && bus.byteReady;
        w_wr_en     = w_push && (!w_full || w_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= 1'b0;
            r_n     <= 2'd0;
            r_asm   <= 8'h00;
        end else if (bus.lineStart) begin
            r_phase <= 1'b0;
            r_n     <= 2'd0;
            r_asm   <= 8'h00;
        end else begin
            r_phase <= bus.div2 ? ~r_phase : 1'b0;
            if (w_sample) begin
                r_n   <= r_n + 2'd1;
                r_asm <= (r_n == 2'd3) ? 8'h00 : w_asm_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en && !reset) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_last     <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_last   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // When empty, byteData shows the most recently popped byte rather than a stale slot.
    assign bus.byteValid = (r_count != '0);
    assign bus.byteData  = (r_count == '0) ? r_last : r_mem[r_rd_ptr];
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_video_pixel_packer.sv
// Self-checking bench for video_pixel_packer (FIFO_DEPTH=2); expected bytes flow through exp_q.
module tb_video_pixel_packer;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    video_pixel_packer_if bus();

    video_pixel_packer #(.FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: scoreboard check on the falling edge, then return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (!rst && bus.byteValid && bus.byteReady) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: got byte %02h, expected none", bus.byteData);
            end else begin
                exp_b = exp_q.pop_front();
                if (bus.byteData !== exp_b) begin
                    n_fail++;
                    $display("FAIL scoreboard: got byte %02h, expected %02h", bus.byteData, exp_b);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.lineStart  = 1'b0;
        bus.pixelValid = 1'b0;
        bus.pixelData  = 2'd0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic send_pixel(input logic [1:0] p);
        bus.pixelValid = 1'b1;
        bus.pixelData  = p;
        tick();
        bus.pixelValid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) begin
            send_pixel(b[7-2*k -: 2]);
        end
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d bytes still expected after %0d cycles, required 0", exp_q.size(), budget);
        end
    endtask

    task automatic test_reset();
        bus.div2      = 1'b0;
        bus.byteReady = 1'b1;
        do_reset();
        n_tests += 3;
        if (bus.byteValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", bus.byteValid); end
        if (bus.byteData !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %02h, expected 00", bus.byteData); end
        if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b, expected 0", bus.overflow); end
    endtask

    task automatic test_full_rate();
        bus.div2      = 1'b0;
        bus.byteReady = 1'b1;
        exp_q.push_back(8'hE4);
        send_byte(8'hE4);
        n_tests += 3;
        if (bus.byteValid !== 1'b1) begin n_fail++; $display("FAIL full_rate_valid: got %b, expected 1", bus.byteValid); end
        if (bus.byteData !== 8'hE4) begin n_fail++; $display("FAIL full_rate_data: got %02h, expected e4", bus.byteData); end
        tick();
        if (bus.byteValid !== 1'b0) begin n_fail++; $display("FAIL full_rate_one_cycle: got %b, expected 0", bus.byteValid); end
    endtask

    task automatic test_half_rate();
        logic [1:0] seq0 [8];
        logic [1:0] vals [4];
        seq0 = '{2'd3, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
        vals = '{2'd1, 2'd2, 2'd3, 2'd0};
        bus.div2      = 1'b1;
        bus.byteReady = 1'b1;
        do_reset();
        exp_q.push_back(8'h00);
        bus.pixelValid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.pixelData = seq0[i];
            tick();
        end
        n_tests += 2;
        if (bus.byteValid !== 1'b1 || bus.byteData !== 8'h00) begin
            n_fail++;
            $display("FAIL half_rate_00: got valid=%b data=%02h, expected valid=1 data=00", bus.byteValid, bus.byteData);
        end
        exp_q.push_back(8'h6C);
        for (int k = 0; k < 4; k++) begin
            bus.pixelData = 2'($urandom_range(3, 0));
            tick();
            bus.pixelData = vals[k];
            tick();
        end
        bus.pixelValid = 1'b0;
        if (bus.byteValid !== 1'b1 || bus.byteData !== 8'h6C) begin
            n_fail++;
            $display("FAIL half_rate_6c: got valid=%b data=%02h, expected valid=1 data=6c", bus.byteValid, bus.byteData);
        end
        drain(4);
    endtask

    task automatic test_overflow();
        bus.div2      = 1'b0;
        bus.byteReady = 1'b0;
        do_reset();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_byte(8'h11);
        send_byte(8'h22);
        n_tests++;
        if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_early: got %b, expected 0", bus.overflow); end
        send_byte(8'h33);
        n_tests += 2;
        if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %b, expected 1", bus.overflow); end
        if (bus.byteValid !== 1'b1 || bus.byteData !== 8'h11) begin
            n_fail++;
            $display("FAIL overflow_head: got valid=%b data=%02h, expected valid=1 data=11", bus.byteValid, bus.byteData);
        end
        bus.byteReady = 1'b1;
        drain(6);
        n_tests += 2;
        if (bus.byteValid !== 1'b0) begin n_fail++; $display("FAIL overflow_empty: got %b, expected 0", bus.byteValid); end
        if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %b, expected 1", bus.overflow); end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] b;
        b = 8'hC3;
        bus.div2      = 1'b0;
        bus.byteReady = 1'b0;
        do_reset();
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hB2);
        exp_q.push_back(b);
        send_byte(8'hA1);
        send_byte(8'hB2);
        for (int k = 0; k < 3; k++) begin
            send_pixel(b[7-2*k -: 2]);
        end
        bus.byteReady = 1'b1;
        send_pixel(b[1:0]);
        n_tests++;
        if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL push_pop_full_overflow: got %b, expected 0", bus.overflow); end
        drain(6);
    endtask

    task automatic test_line_start();
        bus.div2      = 1'b0;
        bus.byteReady = 1'b1;
        do_reset();
`ifdef VIDEO_PACKER_PARTIAL_FLUSH_EN
        exp_q.push_back(8'hD0);
`endif
        send_pixel(2'd3);
        send_pixel(2'd1);
        bus.lineStart  = 1'b1;
        bus.pixelValid = 1'b1;
        bus.pixelData  = 2'd3;
        tick();
        bus.lineStart  = 1'b0;
        bus.pixelValid = 1'b0;
        exp_q.push_back(8'h1B);
        send_byte(8'h1B);
        drain(6);
        tick();
        n_tests++;
        if (bus.byteValid !== 1'b0) begin n_fail++; $display("FAIL line_start_extra: got valid=%b, expected 0", bus.byteValid); end
    endtask

    task automatic test_div2_switch();
        bus.div2      = 1'b0;
        bus.byteReady = 1'b1;
        do_reset();
        exp_q.push_back(8'hE4);
        send_pixel(2'd3);
        send_pixel(2'd2);
        bus.div2       = 1'b1;
        bus.pixelValid = 1'b1;
        bus.pixelData  = 2'd1;
        tick();
        tick();
        bus.pixelData  = 2'd0;
        tick();
        tick();
        bus.pixelValid = 1'b0;
        n_tests++;
        if (bus.byteValid !== 1'b1 || bus.byteData !== 8'hE4) begin
            n_fail++;
            $display("FAIL div2_switch: got valid=%b data=%02h, expected valid=1 data=e4", bus.byteValid, bus.byteData);
        end
        drain(4);
        bus.div2 = 1'b0;
    endtask

    task automatic test_reset_mid_byte();
        bus.div2      = 1'b0;
        bus.byteReady = 1'b0;
        do_reset();
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        send_pixel(2'd2);
        send_pixel(2'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        n_tests += 3;
        if (bus.byteValid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_valid: got %b, expected 0", bus.byteValid); end
        if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_mid_overflow: got %b, expected 0", bus.overflow); end
        if (bus.byteData !== 8'h00) begin n_fail++; $display("FAIL reset_mid_data: got %02h, expected 00", bus.byteData); end
        bus.byteReady = 1'b1;
        exp_q.push_back(8'h9C);
        send_byte(8'h9C);
        drain(4);
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        bus.div2      = 1'b0;
        bus.byteReady = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(255, 0));
            exp_q.push_back(b);
            send_byte(b);
        end
        drain(6);
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.div2       = 1'b0;
        bus.lineStart  = 1'b0;
        bus.pixelValid = 1'b0;
        bus.pixelData  = 2'd0;
        bus.byteReady  = 1'b0;
        test_reset();
        test_full_rate();
        test_half_rate();
        test_overflow();
        test_push_pop_full();
        test_line_start();
        test_div2_switch();
        test_reset_mid_byte();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
